// File: rtl/if_id_pipe_ctrl_pkg.sv
// Shared pipeline definitions: instruction encodings, PC width and the
// fetch-control state encoding used by the hazard unit and the decoder.
package if_id_pipe_ctrl_pkg;

  localparam int PC_W = 32;

  localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;
  localparam logic [31:0] INSTR_HALT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2
  } pipe_state_t;

  // Sequential fetch address; wraps naturally at 32 bits.
  function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc_in);
    return pc_in + PC_W'(4);
  endfunction

endpackage

// File: rtl/if_id_pipe_ctrl.sv
// IF stage and IF/ID register control: PC sequencing, hazard hold,
// branch redirect, HALT drain sequencing and a saturating hold counter.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_RUN    | normal fetch; hold / branch / HALT detection active
//   ST_DRAIN  | HALT seen; PC frozen, NOPs pushed until the pipe empties
//   ST_HALTED | pipeline drained; everything frozen until reset
module if_id_pipe_ctrl
  import if_id_pipe_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = 32'h0000_0000,
  parameter int              DRAIN_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            stall,
  input  logic            flush_idex,
  input  logic            branch_taken,
  input  logic [31:0]     branch_target,
  input  logic [31:0]     imem_data,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     if_id_instr,
  output logic [31:0]     if_id_pc4,
  output logic            id_ex_bubble,
  output logic            halted,
  output logic [15:0]     stall_count
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  pipe_state_t      r_state;
  logic [CNT_W-1:0] r_drain_cnt;
  logic             r_halted;
  logic [PC_W-1:0]  r_pc;
  logic [31:0]      r_instr;
  logic [31:0]      r_pc4;
  logic [15:0]      r_stall_cnt;

  logic             w_hold;
  logic             w_run;
  logic             w_halt_fetch;
  logic [PC_W-1:0]  w_pc_next;

  assign w_hold       = stall | flush_idex;
  assign w_run        = (r_state == ST_RUN);
  assign w_pc_next    = pc_plus4(r_pc);
  // A HALT fetched under a taken branch is on the wrong path and is dropped.
  assign w_halt_fetch = w_run & ~w_hold & ~branch_taken & (imem_data == INSTR_HALT);

  // Control sequencing: RUN -> DRAIN on HALT fetch, DRAIN -> HALTED after the drain window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_halted    <= 1'b0;
    end else if (enable) begin
      case (r_state)
        ST_RUN: begin
          if (w_halt_fetch) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == CNT_LAST) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + CNT_W'(1);
          end
        end
        ST_HALTED: r_halted <= 1'b1;
        default:   r_state  <= ST_RUN;
      endcase
    end
  end

  // Datapath registers: PC, IF/ID pair and the saturating hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_instr     <= INSTR_NOP;
      r_pc4       <= '0;
      r_stall_cnt <= '0;
    end else if (enable && w_run) begin
      if (w_hold) begin
        if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      end else if (branch_taken) begin
        r_pc    <= branch_target;
        r_instr <= INSTR_NOP;
        r_pc4   <= w_pc_next;
      end else if (imem_data == INSTR_HALT) begin
        r_instr <= INSTR_HALT;
      end else begin
        r_pc    <= w_pc_next;
        r_instr <= imem_data;
        r_pc4   <= w_pc_next;
      end
    end else if (enable && (r_state == ST_DRAIN)) begin
      r_instr <= INSTR_NOP;
    end
  end

  assign id_ex_bubble = enable & (w_hold | ~w_run);
  assign pc           = r_pc;
  assign if_id_instr  = r_instr;
  assign if_id_pc4    = r_pc4;
  assign halted       = r_halted;
  assign stall_count  = r_stall_cnt;

endmodule

// File: tb/tb_if_id_pipe_ctrl.sv
// Bench for if_id_pipe_ctrl: directed scenarios followed by random traffic,
// all compared against a behavioural fetch model.
module tb_if_id_pipe_ctrl;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          DRAIN_CYCLES = 4;
  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [31:0] HALT         = 32'hFFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        stall;
  logic        flush_idex;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        id_ex_bubble;
  logic        halted;
  logic [15:0] stall_count;

  logic [31:0] mem [0:255];
  assign imem_data = mem[pc[9:2]];

  if_id_pipe_ctrl #(
    .RESET_PC     (RESET_PC),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .stall         (stall),
    .flush_idex    (flush_idex),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_data     (imem_data),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .id_ex_bubble  (id_ex_bubble),
    .halted        (halted),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: m_left < 0 means fetching; otherwise NOP cycles still to go before halt.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  int          m_left = -1;
  int          m_sc   = 0;
  int          total  = 0;
  int          bad    = 0;

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] word;
    word = mem[m_pc[9:2]];
    if (reset) begin
      m_pc = RESET_PC; m_instr = NOP; m_pc4 = 32'd0; m_left = -1; m_sc = 0;
    end else if (enable) begin
      if (m_left < 0) begin
        if (stall || flush_idex) begin
          m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
        end else if (branch_taken) begin
          m_pc4 = m_pc + 32'd4; m_pc = branch_target; m_instr = NOP;
        end else if (word == HALT) begin
          m_instr = HALT; m_left = DRAIN_CYCLES;
        end else begin
          m_instr = word; m_pc = m_pc + 32'd4; m_pc4 = m_pc;
        end
      end else if (m_left > 0) begin
        m_left--; m_instr = NOP;
      end
    end
  endtask

  task automatic cyc(input string tag);
    logic exp_bub;
    #1;
    exp_bub = enable & (stall | flush_idex | (m_left >= 0));
    chk(tag, "bubble", {31'd0, id_ex_bubble}, {31'd0, exp_bub});
    @(posedge clk); #1;
    model_step();
    chk(tag, "pc",     pc,          m_pc);
    chk(tag, "instr",  if_id_instr, m_instr);
    chk(tag, "pc4",    if_id_pc4,   m_pc4);
    chk(tag, "halted", {31'd0, halted}, {31'd0, (m_left == 0)});
    chk(tag, "scount", {16'd0, stall_count}, 32'(m_sc));
  endtask

  task automatic drive(input logic en, input logic st, input logic fl, input logic br, input logic [31:0] tgt);
    enable = en; stall = st; flush_idex = fl; branch_taken = br; branch_target = tgt;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);

    // reset state
    cyc("rst"); cyc("rst");
    chk("rst", "pc_const", pc, RESET_PC);
    chk("rst", "instr_const", if_id_instr, NOP);
    reset = 1'b0;

    // straight-line fetch, load-use stall at pc=8
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc("fetch");
    chk("fetch", "instr_I0", if_id_instr, 32'h1000_0000);
    cyc("fetch");
    chk("fetch", "pc_8", pc, 32'h8);
    stall = 1'b1; cyc("stall");
    chk("stall", "pc_held", pc, 32'h8);
    chk("stall", "scount_1", {16'd0, stall_count}, 32'd1);
    stall = 1'b0; cyc("fetch"); cyc("fetch");
    chk("fetch", "pc_10", pc, 32'h10);

    // branch blocked by hold, then taken
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40); cyc("br_hold");
    chk("br_hold", "pc_10", pc, 32'h10);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h40); cyc("br");
    chk("br", "pc_40", pc, 32'h40);
    chk("br", "instr_nop", if_id_instr, NOP);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0); cyc("flush");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0); cyc("fetch");

    // enable low freezes everything, bubble stays low
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 32'h80);
      cyc("freeze");
    end

    // 32-bit PC wrap
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC); cyc("wrap_br");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0); cyc("wrap");
    chk("wrap", "pc_0", pc, 32'h0);
    chk("wrap", "pc4_0", if_id_pc4, 32'h0);

    // HALT at 0x20: 4 drain cycles, halted on the 5th edge, sticky until reset
    mem[8] = HALT;
    reset = 1'b1; cyc("h_rst"); reset = 1'b0;
    for (int i = 0; i < 8; i++) cyc("h_run");
    chk("h_run", "pc_20", pc, 32'h20);
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      stall = (i == 1);
      cyc("h_drain");
      chk("h_drain", "halted_0", {31'd0, halted}, 32'd0);
      chk("h_drain", "pc_frozen", pc, 32'h20);
    end
    stall = 1'b0;
    cyc("h_last");
    chk("h_last", "halted_1", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 32'h44);
      cyc("h_stay");
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b1; cyc("h_exit"); reset = 1'b0;
    chk("h_exit", "halted_0", {31'd0, halted}, 32'd0);

    // reset in the middle of DRAIN
    for (int i = 0; i < 9; i++) cyc("d_run");
    cyc("d_drain");
    reset = 1'b1; enable = 1'b0; cyc("d_rst"); reset = 1'b0; enable = 1'b1;
    chk("d_rst", "pc_reset", pc, RESET_PC);
    cyc("d_after");

    // wrong-path HALT under a taken branch
    reset = 1'b1; cyc("w_rst"); reset = 1'b0;
    for (int i = 0; i < 8; i++) cyc("w_run");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h80); cyc("w_br");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0); cyc("w_after");
    chk("w_after", "pc_84", pc, 32'h84);
    mem[8] = 32'h1000_0008;

    // random traffic
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 29) == 0) ? HALT : $urandom;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 6) == 0), 32'($urandom_range(0, 255)) << 2);
      cyc("rand");
    end

    // saturating hold counter
    reset = 1'b1; drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0); cyc("s_rst"); reset = 1'b0;
    stall = 1'b1;
    #1;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      model_step();
    end
    #1;
    chk("sat", "scount_ffff", {16'd0, stall_count}, 32'h0000_FFFF);
    cyc("sat");
    chk("sat", "scount_hold", {16'd0, stall_count}, 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
